// File: rtl/rect_pkg.sv
// Shared types for the rectangle draw sequencer: FSM state encoding,
// coordinate width and the queued command layout.
package rect_pkg;

  localparam int COORD_W     = 7;
  localparam int CMD_COLOR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_X  = 3'd1,
    S_LOAD_Y  = 3'd2,
    S_START   = 3'd3,
    S_WAIT_HI = 3'd4,
    S_WAIT_LO = 3'd5
  } state_t;

  // Colour field is sized for the widest supported palette; narrower
  // instances zero-extend on the way in and truncate on the way out.
  typedef struct packed {
    logic [COORD_W-1:0]     x;
    logic [COORD_W-1:0]     y;
    logic [CMD_COLOR_W-1:0] color;
  } cmd_t;

endpackage

// File: rtl/rect_draw_ctrl_if.sv
// Draw-request channel: valid/ready handshake carrying one rectangle
// (top-left x, y and colour).
interface rect_draw_ctrl_if #(
  parameter int COLOR_W = 3
);
  logic                        req_valid;
  logic                        req_ready;
  logic [rect_pkg::COORD_W-1:0] req_x;
  logic [rect_pkg::COORD_W-1:0] req_y;
  logic [COLOR_W-1:0]          req_color;

  modport master (
    output req_valid, req_x, req_y, req_color,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_x, req_y, req_color,
    output req_ready
  );
endinterface

// File: rtl/rect_cmd_fifo.sv
// Small synchronous FIFO with a combinational head view so the consumer
// can pop and capture the head on the same edge.
module rect_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Overflow/underflow requests are ignored rather than corrupting state.
  assign wr_en = push_i && !full_o;
  assign rd_en = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/rect_draw_ctrl.sv
// Rectangle command sequencer: queues draw requests and, one at a time,
// loads x/y into the datapath, starts it and waits out its write burst.
module rect_draw_ctrl
  import rect_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int COLOR_W = 3,
  parameter int TIMEOUT = 8,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               resetn,
  rect_draw_ctrl_if.slave    req,
  output logic [COORD_W-1:0] data_out,
  output logic               ld_x,
  output logic               ld_y,
  output logic               start_count,
  input  logic               draw_en,
  output logic [COLOR_W-1:0] color,
  output logic               done,
  output logic               err,
  output logic               busy,
  output logic [LW-1:0]      level
);

  localparam int FIFO_W = 2 * COORD_W + COLOR_W;
  localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [COORD_W-1:0]  x_q, y_q;
  logic [COLOR_W-1:0]  color_q;
  logic                done_q;
  logic                rdy_en_q;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic [FIFO_W-1:0]   fifo_rdata;
  cmd_t                head;

  // req_ready stays low during reset and for the reset-release edge.
  assign req.req_ready = rdy_en_q && !fifo_full;
  assign push          = req.req_valid && req.req_ready;

  rect_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .srst    (resetn),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({req.req_x, req.req_y, req.req_color}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign head = '{
    x:     fifo_rdata[FIFO_W-1 -: COORD_W],
    y:     fifo_rdata[COLOR_W +: COORD_W],
    color: CMD_COLOR_W'(fifo_rdata[COLOR_W-1:0])
  };

  assign color = color_q;
  assign done  = done_q;
  assign busy  = (state_q != S_IDLE) || !fifo_empty;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pop         = 1'b0;
    err         = 1'b0;
    ld_x        = 1'b0;
    ld_y        = 1'b0;
    start_count = 1'b0;
    data_out    = '0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_LOAD_X;
        end
      end
      S_LOAD_X: begin
        ld_x     = 1'b1;
        data_out = x_q;
        state_d  = S_LOAD_Y;
      end
      S_LOAD_Y: begin
        ld_y     = 1'b1;
        data_out = y_q;
        state_d  = S_START;
      end
      S_START: begin
        start_count = 1'b1;
        wait_cnt_d  = '0;
        state_d     = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // err fires in the last allowed cycle if draw_en is still low.
        if (draw_en) begin
          state_d = S_WAIT_LO;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!draw_en) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      done_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      done_q     <= (state_q == S_WAIT_LO) && !draw_en;
      rdy_en_q   <= 1'b1;
      if (pop) begin
        x_q     <= head.x;
        y_q     <= head.y;
        color_q <= COLOR_W'(head.color);
      end
    end
  end

endmodule

// File: tb/tb_rect_draw_ctrl.sv
// Bench for rect_draw_ctrl: queued requests and a datapath stand-in are
// tracked at transaction level and every cycle is checked against them.
module tb_rect_draw_ctrl;

  localparam int DEPTH   = 4;
  localparam int COLOR_W = 3;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic [6:0] data_out;
  logic       ld_x, ld_y, start_count, draw_en;
  logic [2:0] color;
  logic       done, err, busy;
  logic [2:0] level;

  rect_draw_ctrl_if #(.COLOR_W(COLOR_W)) req_if ();

  rect_draw_ctrl #(
    .DEPTH   (DEPTH),
    .COLOR_W (COLOR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req_if),
    .data_out    (data_out),
    .ld_x        (ld_x),
    .ld_y        (ld_y),
    .start_count (start_count),
    .draw_en     (draw_en),
    .color       (color),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .level       (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         burst;   // draw_en high cycles; 0 = datapath never responds
  } rq_t;

  rq_t        send_q[$];
  rq_t        model_q[$];
  rq_t        cur;
  int         total = 0;
  int         bad = 0;
  int         phase = 0;    // 0 idle, 1 x loaded, 2 y loaded, 3 waiting on burst
  int         k = 0;        // cycles since start_count
  logic [2:0] exp_color = '0;
  bit         idle_prev = 1'b1;
  int         prev_qsize = 0;
  int         done_seen = 0;
  int         err_seen = 0;
  int         max_level = 0;
  int         s_level = 0;

  function automatic rq_t mk(input int x, input int y, input int c, input int b);
    rq_t r;
    r.x = x[6:0];
    r.y = y[6:0];
    r.c = c[2:0];
    r.burst = b;
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, sample at negedge, compare, then advance models.
  task automatic cycle();
    int  ph;
    bit  acc, new_draw, exp_ldx, exp_done, exp_err, fsm_idle;
    int  e_data;
    if (send_q.size() > 0) begin
      req_if.req_valid = 1'b1;
      req_if.req_x     = send_q[0].x;
      req_if.req_y     = send_q[0].y;
      req_if.req_color = send_q[0].c;
    end else begin
      req_if.req_valid = 1'b0;
      req_if.req_x     = '0;
      req_if.req_y     = '0;
      req_if.req_color = '0;
    end
    draw_en = (phase == 3) && (k >= 1) && (k <= cur.burst);
    @(negedge clk);
    ph       = phase;
    exp_ldx  = idle_prev && (prev_qsize > 0);
    exp_done = (ph == 3) && (cur.burst > 0) && (k == cur.burst + 2);
    exp_err  = (ph == 3) && (cur.burst == 0) && (k == TIMEOUT);
    chk("ld_x", int'(ld_x), int'(exp_ldx));
    new_draw = ld_x && (model_q.size() > 0);
    if (new_draw) begin
      cur       = model_q.pop_front();
      exp_color = cur.c;
    end
    e_data = new_draw ? int'(cur.x) : ((ph == 1) ? int'(cur.y) : 0);
    chk("ld_y", int'(ld_y), int'(ph == 1));
    chk("start_count", int'(start_count), int'(ph == 2));
    chk("data_out", int'(data_out), e_data);
    chk("done", int'(done), int'(exp_done));
    chk("err", int'(err), int'(exp_err));
    chk("color", int'(color), int'(exp_color));
    chk("level", int'(level), model_q.size());
    fsm_idle = ((ph == 0) && !new_draw) || exp_done;
    chk("busy", int'(busy), int'(!fsm_idle || (model_q.size() > 0)));
    chk("req_ready", int'(req_if.req_ready), int'(model_q.size() < DEPTH));
    if (done) done_seen++;
    if (err) err_seen++;
    s_level = int'(level);
    if (s_level > max_level) max_level = s_level;
    if (new_draw) phase = 1;
    else if (ph == 1) phase = 2;
    else if (ph == 2) begin phase = 3; k = 0; end
    else if ((ph == 3) && (exp_done || exp_err)) phase = 0;
    idle_prev  = fsm_idle;
    prev_qsize = model_q.size();
    acc = req_if.req_valid && req_if.req_ready;
    @(posedge clk);
    #1;
    if (acc) model_q.push_back(send_q.pop_front());
    if (phase == 3) k++;
  endtask

  task automatic do_reset(input int n);
    resetn           = 1'b1;
    req_if.req_valid = 1'b0;
    draw_en          = 1'b0;
    send_q.delete();
    repeat (n) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_level", int'(level), 0);
    chk("rst_strobes", int'({ld_x, ld_y, start_count}), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_color", int'(color), 0);
    chk("rst_ready", int'(req_if.req_ready), 0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    model_q.delete();
    phase      = 0;
    k          = 0;
    exp_color  = '0;
    idle_prev  = 1'b1;
    prev_qsize = 0;
    @(negedge clk);
    chk("ready_release_edge", int'(req_if.req_ready), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((send_q.size() > 0 || model_q.size() > 0 || phase != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_within_budget", send_q.size() + model_q.size() + phase, 0);
    cycle();
  endtask

  initial begin
    int d0, e0, nd, ne, n, b;
    req_if.req_valid = 1'b0;
    req_if.req_x     = '0;
    req_if.req_y     = '0;
    req_if.req_color = '0;
    draw_en          = 1'b0;
    do_reset(3);

    // Single rectangle, 16-cycle burst.
    d0 = done_seen;
    send_q.push_back(mk(10, 20, 3, 16));
    drain(100);
    chk("t1_done_pulses", done_seen - d0, 1);
    $display("txn single x=10 y=20 c=3 done_pulses=%0d", done_seen - d0);

    // Six requests against a stalled datapath: FIFO fills and back-pressures.
    d0 = done_seen;
    max_level = 0;
    for (int i = 0; i < 6; i++)
      send_q.push_back(mk($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 7), 20));
    drain(400);
    chk("t2_max_level", max_level, DEPTH);
    chk("t2_done_pulses", done_seen - d0, 6);
    $display("txn backpressure reqs=6 max_level=%0d", max_level);

    // Timeout followed by a normal request.
    d0 = done_seen;
    e0 = err_seen;
    send_q.push_back(mk(5, 6, 1, 0));
    send_q.push_back(mk(7, 8, 2, 3));
    drain(100);
    chk("t3_err_pulses", err_seen - e0, 1);
    chk("t3_done_pulses", done_seen - d0, 1);
    $display("txn timeout err_pulses=%0d", err_seen - e0);

    // Reset while in WAIT_LO with two entries queued.
    d0 = done_seen;
    send_q.push_back(mk(33, 44, 5, 30));
    send_q.push_back(mk(1, 2, 6, 3));
    send_q.push_back(mk(3, 4, 7, 3));
    n = 0;
    while (!(phase == 3 && k >= 3 && model_q.size() == 2) && n < 50) begin
      cycle();
      n++;
    end
    chk("t4_reached_wait_lo", int'(phase == 3 && k >= 3 && model_q.size() == 2), 1);
    do_reset(1);
    cycle();
    cycle();
    chk("t4_no_done", done_seen - d0, 0);
    $display("txn reset_in_wait_lo done_pulses=%0d", done_seen - d0);

    // Push and pop on the same edge at level 2.
    send_q.push_back(mk(11, 12, 1, 10));
    send_q.push_back(mk(13, 14, 2, 2));
    send_q.push_back(mk(15, 16, 3, 2));
    n = 0;
    while (!(phase == 3 && k == cur.burst + 2) && n < 60) begin
      cycle();
      n++;
    end
    chk("t5_pre_level", s_level, 2);
    send_q.push_back(mk(17, 18, 4, 2));
    cycle();
    cycle();
    chk("t5_level_after_push_pop", s_level, 2);
    drain(200);
    $display("txn push_pop_same_edge level=%0d", s_level);

    // Full-range coordinates.
    send_q.push_back(mk(127, 127, 7, 2));
    drain(60);
    $display("txn max_coord x=127 y=127");

    // Random requests, including timeouts.
    d0 = done_seen;
    e0 = err_seen;
    nd = 0;
    ne = 0;
    for (int i = 0; i < 20; i++) begin
      b = $urandom_range(0, 6);
      if (b == 0) ne++; else nd++;
      send_q.push_back(mk($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 7), b));
    end
    drain(2000);
    chk("t7_done_pulses", done_seen - d0, nd);
    chk("t7_err_pulses", err_seen - e0, ne);
    $display("txn random reqs=20 done=%0d err=%0d", done_seen - d0, err_seen - e0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
